// File: rtl/bash_hash_axil_master.sv
// bash_hash_axil_master
// AXI4-Lite initiator for the bash hash core's 8-bit register space.
// It turns a valid/ready command stream (one read or write) into a single
// AXI4-Lite transaction and returns the completion on a response stream.
// Only one transaction is in flight at a time. Every output is registered,
// so no m_axi input reaches an m_axi output combinationally.
//
// Optional build macro: BASH_HASH_AXIL_ALIGN_CHECK_EN
//   When defined, a command whose cmd_addr[1:0] is not zero generates no bus
//   traffic. It completes with SLVERR one cycle after it is accepted.
module bash_hash_axil_master #(
    parameter int         ADDR_W = 8,
    parameter int         DATA_W = 32,
    parameter logic [2:0] PROT   = 3'b000
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t              state_reg, state_next;

    logic                cmd_ready_reg, cmd_ready_next;
    logic                awvalid_reg, awvalid_next;
    logic                wvalid_reg, wvalid_next;
    logic                bready_reg, bready_next;
    logic                arvalid_reg, arvalid_next;
    logic                rready_reg, rready_next;
    logic                rsp_valid_reg, rsp_valid_next;

    logic [ADDR_W-1:0]   awaddr_reg, awaddr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic [ADDR_W-1:0]   araddr_reg, araddr_next;
    logic                rsp_write_reg, rsp_write_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]          rsp_resp_reg, rsp_resp_next;

    logic                misaligned;
    logic                aw_done;
    logic                w_done;

`ifdef BASH_HASH_AXIL_ALIGN_CHECK_EN
    assign misaligned = (cmd_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A write channel counts as finished once its valid has dropped, or when
    // its handshake happens in the current cycle.
    assign aw_done = !awvalid_reg || m_axi_awready;
    assign w_done  = !wvalid_reg  || m_axi_wready;

    // State and registered outputs; asynchronous reset returns to IDLE and
    // discards any in-flight command or response.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            araddr_reg    <= '0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            awaddr_reg    <= awaddr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            araddr_reg    <= araddr_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        awaddr_next    = awaddr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        araddr_next    = araddr_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    if (misaligned) begin
                        // Refuse locally; the slave never sees this access.
                        rsp_valid_next = 1'b1;
                        rsp_write_next = cmd_write;
                        rsp_rdata_next = '0;
                        rsp_resp_next  = 2'b10;
                        state_next     = RSP;
                    end else if (cmd_write) begin
                        awaddr_next  = cmd_addr;
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_ADDR_DATA;
                    end else begin
                        araddr_next  = cmd_addr;
                        arvalid_next = 1'b1;
                        state_next   = RD_ADDR;
                    end
                end
            end

            WR_ADDR_DATA: begin
                if (awvalid_reg && m_axi_awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && m_axi_wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (bready_reg && m_axi_bvalid) begin
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_resp_next  = m_axi_bresp;
                    state_next     = RSP;
                end
            end

            RD_ADDR: begin
                if (arvalid_reg && m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rready_reg && m_axi_rvalid) begin
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_write_next = 1'b0;
                    rsp_rdata_next = m_axi_rdata;
                    rsp_resp_next  = m_axi_rresp;
                    state_next     = RSP;
                end
            end

            RSP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready     = cmd_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_write     = rsp_write_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;

    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_bash_hash_axil_master.sv
// tb_bash_hash_axil_master
// Directed bench for bash_hash_axil_master. Commands are driven one edge-step
// at a time; each issue pushes its expected completion into a queue, and a
// monitor pops and compares whenever a response handshake is about to occur.
// A small AXI4-Lite slave model with programmable per-channel waits answers
// the bus and counts beats and protocol violations.
module tb_bash_hash_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [7:0]  m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        m_axi_bready;
    logic [7:0]  m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        m_axi_rready;

    bash_hash_axil_master dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    // edge counter: at any point between edges, the next edge is cyc+1
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // slave model configuration and observation
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = 32'h0;
    int          aw_beats = 0, w_beats = 0, ar_beats = 0;
    logic [7:0]  last_awaddr = 8'h0, last_araddr = 8'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;
    int          bready_viol = 0, ar_viol = 0, beat_viol = 0;

    logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic        b_fire = 1'b0, r_fire = 1'b0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic        ar_prev_valid = 1'b0, ar_prev_hs = 1'b0;
    logic [7:0]  ar_prev_addr = 8'h0;

    // AXI4-Lite slave: reacts on the falling edge so its outputs are stable
    // at the following rising edge. Response channels are updated before the
    // address/data channels so B/R only follow completed earlier beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            ar_prev_valid = 0; ar_prev_hs = 0;
        end else begin
            if (m_axi_bready && !(aw_got && w_got)) bready_viol++;
            if (m_axi_awvalid && aw_got) beat_viol++;
            if (m_axi_wvalid && w_got) beat_viol++;
            if (m_axi_arvalid && ar_got) beat_viol++;
            if (ar_prev_valid && !ar_prev_hs &&
                (!m_axi_arvalid || m_axi_araddr != ar_prev_addr)) ar_viol++;

            // B channel
            if (b_fire) begin
                bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; b_wait = 0;
            end else if (aw_got && w_got) begin
                if (!bvalid) begin
                    if (b_wait >= b_delay) begin bvalid = 1; bresp = bresp_val; end
                    else b_wait++;
                end
                if (bvalid && m_axi_bready) b_fire = 1;
            end
            // R channel
            if (r_fire) begin
                rvalid = 0; r_fire = 0; ar_got = 0; r_wait = 0; rdata = 0;
            end else if (ar_got) begin
                if (!rvalid) begin
                    if (r_wait >= r_delay) begin rvalid = 1; rdata = rdata_val; rresp = rresp_val; end
                    else r_wait++;
                end
                if (rvalid && m_axi_rready) r_fire = 1;
            end
            // AW channel
            if (m_axi_awvalid && !aw_got) begin
                if (aw_wait >= aw_delay) awready = 1;
                else begin awready = 0; aw_wait++; end
            end else begin awready = 0; aw_wait = 0; end
            if (m_axi_awvalid && awready) begin
                aw_got = 1; aw_beats++; last_awaddr = m_axi_awaddr;
            end
            // W channel
            if (m_axi_wvalid && !w_got) begin
                if (w_wait >= w_delay) wready = 1;
                else begin wready = 0; w_wait++; end
            end else begin wready = 0; w_wait = 0; end
            if (m_axi_wvalid && wready) begin
                w_got = 1; w_beats++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
            end
            // AR channel
            if (m_axi_arvalid && !ar_got) begin
                if (ar_wait >= ar_delay) arready = 1;
                else begin arready = 0; ar_wait++; end
            end else begin arready = 0; ar_wait = 0; end
            ar_prev_valid = m_axi_arvalid;
            ar_prev_hs    = m_axi_arvalid && arready;
            ar_prev_addr  = m_axi_araddr;
            if (m_axi_arvalid && arready) begin
                ar_got = 1; ar_beats++; last_araddr = m_axi_araddr;
            end
        end
    end

    // response monitor / scoreboard
    int          cmd_edge = 0;
    int          rsp_hs_edge = 0;
    int          first_edge = 0;
    int          rsp_viol = 0;
    logic        rsp_seen = 1'b0;
    logic [34:0] rsp_snap = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_seen = 0;
        end else begin
            if (rsp_valid && !rsp_seen) begin
                rsp_seen   = 1;
                first_edge = cyc + 1;
                rsp_snap   = {rsp_write, rsp_resp, rsp_rdata};
            end
            if (rsp_valid) begin
                if ({rsp_write, rsp_resp, rsp_rdata} != rsp_snap) rsp_viol++;
                if (cmd_ready) rsp_viol++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_hs_edge = cyc + 1;
                rsp_seen = 0;
                $display("[TB] rsp wr=%0d rdata=0x%08h resp=%0d lat=%0d",
                         rsp_write, rsp_rdata, rsp_resp, first_edge - cmd_edge);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got a response, expected none");
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_write", {31'b0, rsp_write}, {31'b0, mon_e.wr});
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_resp", {30'b0, rsp_resp}, {30'b0, mon_e.resp});
                    if (mon_e.lat >= 0)
                        check("rsp_latency", first_edge - cmd_edge, mon_e.lat);
                end
            end
        end
    end

    // Issue one command; called one time-step after a rising edge.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp_rd,
                         input logic [1:0] exp_resp, input int exp_lat);
        exp_t e;
        int   n;
        e.wr = wr; e.rdata = exp_rd; e.resp = exp_resp; e.lat = exp_lat;
        sb.push_back(e);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_accept", {31'b0, cmd_ready}, 32'd1);
        $display("[TB] cmd wr=%0d addr=0x%02h wdata=0x%08h strb=0x%h", wr, addr, wd, st);
        cmd_edge = cyc + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    int aw0, w0, ar0, stall_rel;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("reset_ctrl", {25'b0, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready, rsp_valid}, 32'b1000000);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_addr", {14'b0, rsp_resp, m_axi_awaddr, m_axi_araddr}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait write
        issue(1'b1, 8'h04, 32'h0000_00A5, 4'hF, 32'h0, 2'b00, 3);
        wait_done();
        check("wr1_aw_beats", aw_beats, 1);
        check("wr1_w_beats", w_beats, 1);
        check("wr1_awaddr", {24'b0, last_awaddr}, 32'h04);
        check("wr1_wdata", last_wdata, 32'h0000_00A5);
        check("wr1_wstrb", {28'b0, last_wstrb}, 32'hF);

        // read with slave waits
        ar_delay = 5; r_delay = 3; rdata_val = 32'hDEAD_BEEF;
        issue(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, -1);
        wait_done();
        check("rd1_ar_beats", ar_beats, 1);
        check("rd1_araddr", {24'b0, last_araddr}, 32'h10);
        check("rd1_ar_stable", ar_viol, 0);
        ar_delay = 0; r_delay = 0;

        // write-channel orderings: W first, AW first, together
        for (int i = 0; i < 3; i++) begin
            aw0 = aw_beats; w0 = w_beats;
            aw_delay = (i == 0) ? 4 : 0;
            w_delay  = (i == 1) ? 4 : 0;
            issue(1'b1, 8'h20 + 8'(i * 4), 32'h1111_0000 + i, 4'h3, 32'h0, 2'b00, -1);
            wait_done();
            check("ord_aw_beat", aw_beats - aw0, 1);
            check("ord_w_beat", w_beats - w0, 1);
            check("ord_wdata", last_wdata, 32'h1111_0000 + i);
        end
        aw_delay = 0; w_delay = 0;
        check("bready_after_both", bready_viol, 0);

        // error responses pass through; next command normal
        bresp_val = 2'b10;
        issue(1'b1, 8'h08, 32'h0BAD_0BAD, 4'hF, 32'h0, 2'b10, 3);
        wait_done();
        bresp_val = 2'b00;
        rresp_val = 2'b11; rdata_val = 32'h1234_5678;
        issue(1'b0, 8'h0C, 32'h0, 4'h0, 32'h1234_5678, 2'b11, 3);
        wait_done();
        rresp_val = 2'b00; rdata_val = 32'hCAFE_F00D;
        issue(1'b0, 8'h0C, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 3);
        wait_done();

        // response back-pressure, then back-to-back command on release
        rsp_ready = 1'b0; rdata_val = 32'h55AA_55AA;
        issue(1'b0, 8'h14, 32'h0, 4'h0, 32'h55AA_55AA, 2'b00, 3);
        for (int n = 0; n < 50 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        stall_rel = cyc + 1;
        issue(1'b1, 8'h18, 32'h0000_0077, 4'hF, 32'h0, 2'b00, 3);
        check("b2b_accept_edge", cmd_edge, stall_rel + 1);
        wait_done();
        check("stall_payload_stable", rsp_viol, 0);

        // reset while waiting on read data
        r_delay = 10;
        issue(1'b0, 8'h1C, 32'h0, 4'h0, 32'h0, 2'b00, -1);
        for (int n = 0; n < 50 && !m_axi_rready; n++) begin
            @(posedge clk); #1;
        end
        check("in_rd_data", {31'b0, m_axi_rready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("rst_async_ctrl", {26'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                 m_axi_arvalid, m_axi_rready, rsp_valid}, 32'b0);
        r_delay = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rdata_val = 32'h0BB0_0BB0;
        issue(1'b0, 8'h24, 32'h0, 4'h0, 32'h0BB0_0BB0, 2'b00, 3);
        wait_done();

        // unaligned address handling
        ar0 = ar_beats; aw0 = aw_beats;
`ifdef BASH_HASH_AXIL_ALIGN_CHECK_EN
        issue(1'b0, 8'h06, 32'h0, 4'h0, 32'h0, 2'b10, 1);
        wait_done();
        check("align_rd_no_ar", ar_beats - ar0, 0);
        issue(1'b1, 8'h07, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10, 1);
        wait_done();
        check("align_wr_no_aw", aw_beats - aw0, 0);
`else
        rdata_val = 32'h0606_0606;
        issue(1'b0, 8'h06, 32'h0, 4'h0, 32'h0606_0606, 2'b00, 3);
        wait_done();
        check("unalign_ar_beat", ar_beats - ar0, 1);
        check("unalign_araddr", {24'b0, last_araddr}, 32'h06);
`endif
        check("no_extra_beats", beat_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bash_hash_axil_master.md
Name: bash_hash_axil_master

Overview:
- AXI4-Lite initiator that drives the bash hash accelerator's 8-bit-address AXI4-Lite register slave from an internal sequencer or testbench.
- Converts a simple valid/ready command stream (single read or write) into AXI4-Lite transactions and returns each completion on a response stream.
- One transaction outstanding at a time. Sits between a control FSM or soft CPU bridge and the hash core's register interface.

Parameters:
- ADDR_W, 8, AXI address width; matches the hash core register space.
- DATA_W, 32, data width. Only 32 is supported; strobe width is DATA_W/8.
- PROT, 3'b000, constant value driven on m_axi_awprot and m_axi_arprot.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  completion present
- rsp_ready  in  1  completion consumed
- rsp_write  out  1  completion type
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- m_axi_awaddr  out  ADDR_W;  m_axi_awprot  out  3;  m_axi_awvalid  out  1;  m_axi_awready  in  1
- m_axi_wdata  out  DATA_W;  m_axi_wstrb  out  DATA_W/8;  m_axi_wvalid  out  1;  m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_araddr  out  ADDR_W;  m_axi_arprot  out  3;  m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rdata  in  DATA_W;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Behaviour:
- Single clock s_axi_aclk. Reset s_axi_aresetn is asynchronous, active-low.
- All outputs are registered.
- Reset values: all valids/readies 0, except cmd_ready=1. Address/data/strobe/rdata/resp outputs 0.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command and drop cmd_ready next cycle.
  - Write: awvalid and wvalid both rise the next cycle; go to WR_ADDR_DATA.
  - Read: arvalid rises the next cycle; go to RD_ADDR.
- WR_ADDR_DATA: AW and W complete independently.
  - awvalid drops the cycle after awready is seen; wvalid drops the cycle after wready is seen.
  - Either order, or both in the same cycle, is legal.
  - Once both have completed, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, capture bresp, drop bready, go to RSP. rsp_rdata=0, rsp_write=1.
- RD_ADDR: hold arvalid and araddr stable until arready. Then drop arvalid, assert rready, go to RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata/rresp, drop rready, go to RSP with rsp_write=0.
- RSP: rsp_valid=1 and held with stable payload until rsp_ready. Then go to IDLE with cmd_ready=1 the following cycle.
- Minimum latency, with a zero-wait slave and rsp_ready tied high:
  - write: cmd handshake at cycle N -> rsp_valid at N+3;
  - read: cmd handshake at N -> rsp_valid at N+3.
- Valid signals never drop before their handshake.
- Payload (addr/data/strb) is stable while the corresponding valid is high.
- No combinational path from any m_axi input to any m_axi output.
- Unexpected bvalid or rvalid outside the matching state is ignored (its ready is 0).
- Reset mid-transaction:
  - all state returns to IDLE asynchronously, all valids drop;
  - the in-flight command and response are discarded;
  - recovery is the responsibility of the system reset, which also resets the slave.
- Response codes are passed through unmodified. SLVERR/DECERR does not change sequencing.

Optional Feature:
- Macro BASH_HASH_AXIL_ALIGN_CHECK_EN.
- Defined: a command with cmd_addr[1:0]!=0 issues no bus activity. The block goes IDLE -> RSP directly and returns rsp_resp=2'b10 (SLVERR), rsp_rdata=0, rsp_write=cmd_write. rsp_valid is asserted 1 cycle after the command handshake.
- Not defined: unaligned addresses are forwarded unchanged to the AXI bus.

Test Plan:
- Write 0x0000_00A5 to addr 0x04, strb 4'hF, zero-wait slave -> one AW and one W beat with awaddr=0x04, wdata=0xA5. rsp_valid at N+3 with rsp_resp=0, rsp_write=1.
- Read addr 0x10, slave returns 0xDEADBEEF after 5 wait cycles on arready and 3 on rvalid -> arvalid held stable throughout. rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Write where wready arrives 4 cycles before awready, then the reverse order, then both in the same cycle -> exactly one beat per channel each time; bready rises only after both beats complete.
- Slave returns bresp=2'b10 and rresp=2'b11 -> passed through on rsp_resp. The next command is accepted normally.
- rsp_ready held low 6 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout. A back-to-back command is accepted the cycle after release.
- Assert s_axi_aresetn low while in RD_DATA -> all valids/readies 0 immediately, cmd_ready=1 after release. With BASH_HASH_AXIL_ALIGN_CHECK_EN, a read of addr 0x06 -> no arvalid, rsp_resp=2'b10 one cycle later.
